// File: rtl/rv_isa_pkg.sv
// RV32I field definitions shared by the instruction
// encoder, its packer and immgen.
package rv_isa_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ERR_RANGE = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_ULOW  = 2'd2,
    ERR_FMT   = 2'd3
  } err_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } enc_state_e;

  function automatic logic in_range(
    input logic signed [31:0] v,
    input int                 lo,
    input int                 hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I packer: fields in, instruction
// word plus legality verdict out.
module inst_pack
  import rv_isa_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] inst_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  logic signed [31:0] simm;

  assign simm = $signed(imm_i);

  always_comb begin
    inst_o     = '0;
    err_o      = 1'b0;
    err_code_o = ERR_RANGE;
    unique case (fmt_i)
      FMT_R: begin
        inst_o = {funct7_i, rs2_i, rs1_i,
                  funct3_i, rd_i, opcode_i};
      end
      FMT_I: begin
        inst_o = {imm_i[11:0], rs1_i,
                  funct3_i, rd_i, opcode_i};
        err_o  = !in_range(simm, -2048, 2047);
      end
      FMT_S: begin
        inst_o = {imm_i[11:5], rs2_i, rs1_i,
                  funct3_i, imm_i[4:0], opcode_i};
        err_o  = !in_range(simm, -2048, 2047);
      end
      FMT_B: begin
        inst_o = {imm_i[12], imm_i[10:5], rs2_i,
                  rs1_i, funct3_i, imm_i[4:1],
                  imm_i[11], opcode_i};
        if (!in_range(simm, -4096, 4094)) begin
          err_o = 1'b1;
        end else if (imm_i[0]) begin
          err_o      = 1'b1;
          err_code_o = ERR_ALIGN;
        end
      end
      FMT_U: begin
        inst_o = {imm_i[31:12], rd_i, opcode_i};
        if (imm_i[11:0] != 12'd0) begin
          err_o      = 1'b1;
          err_code_o = ERR_ULOW;
        end
      end
      FMT_J: begin
        inst_o = {imm_i[20], imm_i[10:1], imm_i[11],
                  imm_i[19:12], rd_i, opcode_i};
        // The odd upper bound is excluded as a range
        // error, so alignment only sees in-range values.
        if (!in_range(simm, -1048576, 1048574)) begin
          err_o = 1'b1;
        end else if (imm_i[0]) begin
          err_o      = 1'b1;
          err_code_o = ERR_ALIGN;
        end
      end
      default: begin
        err_o      = 1'b1;
        err_code_o = ERR_FMT;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: one-entry output buffer with a
// sequential write address and rejection counters.
module inst_encoder
  import rv_isa_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 10,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done,
  output logic [7:0]        err_count,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  logic [31:0] pk_inst;
  logic        pk_err;
  logic [1:0]  pk_code;

  inst_pack u_pack (
    .fmt_i      (in_fmt),
    .opcode_i   (in_opcode),
    .rd_i       (in_rd),
    .rs1_i      (in_rs1),
    .rs2_i      (in_rs2),
    .funct3_i   (in_funct3),
    .funct7_i   (in_funct7),
    .imm_i      (in_imm),
    .inst_o     (pk_inst),
    .err_o      (pk_err),
    .err_code_o (pk_code)
  );

  enc_state_e        state_q, state_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic [7:0]        errc_q, errc_d;
  logic [1:0]        code_q, code_d;
  logic              accept;
  logic              consume;

  always_comb begin
    state_d  = state_q;
    inst_d   = inst_q;
    addr_d   = addr_q;
    last_d   = last_q;
    errc_d   = errc_q;
    code_d   = code_q;
    in_ready = (state_q == ST_EMPTY) || out_ready;
    accept   = in_valid && in_ready;
    consume  = (state_q == ST_FULL) && out_ready;
    done_d   = (consume && last_q)
            || (accept && pk_err && in_last);
    // addr_q is the held word's address while FULL and
    // the next word's address while EMPTY.
    if (consume) begin
      state_d = ST_EMPTY;
      addr_d  = last_q ? BASE_ADDR : addr_q + ADDR_ONE;
    end
    if (accept && !pk_err) begin
      state_d = ST_FULL;
      inst_d  = pk_inst;
      last_d  = in_last;
    end
    if (accept && pk_err) begin
      code_d = pk_code;
      if (errc_q != 8'hFF) begin
        errc_d = errc_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      inst_q  <= '0;
      addr_q  <= BASE_ADDR;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      errc_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      done_q  <= done_d;
      errc_q  <= errc_d;
      code_q  <= code_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_inst  = inst_q;
  assign out_addr  = addr_q;
  assign done      = done_q;
  assign err_count = errc_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed
// cases plus a randomized run against a reference model.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [9:0]  out_addr;
  logic        done;
  logic [7:0]  err_count;
  logic [1:0]  err_code;

  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_inst2;
  logic [1:0]  out_addr2;
  logic        done2;
  logic [7:0]  err_count2;
  logic [1:0]  err_code2;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .done(done), .err_count(err_count),
    .err_code(err_code)
  );

  inst_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_inst(out_inst2), .out_addr(out_addr2),
    .done(done2), .err_count(err_count2),
    .err_code(err_code2)
  );

  // Reference legality: -1 when legal, else the cause.
  function automatic int ref_err(int fmt, int imm);
    if (fmt > 5) return 3;
    case (fmt)
      1, 2: if (imm < -2048 || imm > 2047) return 0;
      3: begin
        if (imm < -4096 || imm > 4094) return 0;
        if (imm % 2 != 0) return 1;
      end
      4: if ((imm & 32'hFFF) != 0) return 2;
      5: begin
        if (imm < -1048576 || imm > 1048574) return 0;
        if (imm % 2 != 0) return 1;
      end
      default: ;
    endcase
    return -1;
  endfunction

  function automatic logic [31:0] ref_enc(
    int fmt, int op, int rd, int rs1, int rs2,
    int f3, int f7, int imm);
    logic [31:0] u;
    logic [31:0] regs;
    u    = imm;
    regs = ((rs1 & 31) << 15) | ((f3 & 7) << 12);
    case (fmt)
      0: return ((f7 & 127) << 25) | ((rs2 & 31) << 20)
              | regs | ((rd & 31) << 7) | (op & 127);
      1: return ((u & 32'hFFF) << 20) | regs
              | ((rd & 31) << 7) | (op & 127);
      2: return (((u >> 5) & 127) << 25)
              | ((rs2 & 31) << 20) | regs
              | ((u & 31) << 7) | (op & 127);
      3: return (((u >> 12) & 1) << 31)
              | (((u >> 5) & 63) << 25)
              | ((rs2 & 31) << 20) | regs
              | (((u >> 1) & 15) << 8)
              | (((u >> 11) & 1) << 7) | (op & 127);
      4: return (u & 32'hFFFFF000)
              | ((rd & 31) << 7) | (op & 127);
      5: return (((u >> 20) & 1) << 31)
              | (((u >> 1) & 1023) << 21)
              | (((u >> 11) & 1) << 20)
              | (((u >> 12) & 255) << 12)
              | ((rd & 31) << 7) | (op & 127);
      default: return 32'd0;
    endcase
  endfunction

  // immgen-style immediate recovery from a word.
  function automatic int dec_imm(int fmt, logic [31:0] w);
    case (fmt)
      1: return int'({{20{w[31]}}, w[31:20]});
      2: return int'({{20{w[31]}}, w[31:25], w[11:7]});
      3: return int'({{19{w[31]}}, w[31], w[7],
                      w[30:25], w[11:8], 1'b0});
      4: return int'({w[31:12], 12'd0});
      5: return int'({{11{w[31]}}, w[31], w[19:12],
                      w[20], w[30:21], 1'b0});
      default: return 0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int fmt, op, rd, rs1,
                       rs2, f3, f7, imm,
                       input bit last);
    in_valid  = 1'b1;
    in_fmt    = 3'(fmt);
    in_opcode = 7'(op);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_funct3 = 3'(f3);
    in_funct7 = 7'(f7);
    in_imm    = imm;
    in_last   = last;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_run++;
    if (out_valid !== 1'b0 || out_inst !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b inst=%h want 0/0",
               out_valid, out_inst);
    end
    n_run++;
    if (out_addr !== 10'd0 || out_addr2 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got %0d/%0d want 0",
               out_addr, out_addr2);
    end
    n_run++;
    if (done !== 1'b0 || err_count !== 8'd0
        || err_code !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_err: done=%b cnt=%0d code=%0d want 0",
               done, err_count, err_code);
    end
    n_run++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    int          fmts[5] = '{1, 2, 3, 5, 4};
    int          ops[5]  = '{'h13, 'h23, 'h63, 'h6F, 'h37};
    int          rds[5]  = '{1, 17, 9, 1, 5};
    int          r1s[5]  = '{2, 4, 5, 0, 0};
    int          r2s[5]  = '{0, 3, 6, 0, 0};
    int          f3s[5]  = '{0, 2, 0, 0, 0};
    int          imms[5] = '{100, -4, -4, 2048, 'h12345000};
    logic [31:0] exp[5]  = '{32'h06410093, 32'hFE322E23,
                             32'hFE628EE3, 32'h001000EF,
                             32'h123452B7};
    int r2;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      r2 = (fmts[i] == 2 || fmts[i] == 3)
           ? r2s[i] : int'($urandom_range(0, 31));
      drive(fmts[i], ops[i], rds[i], r1s[i], r2,
            f3s[i], int'($urandom_range(0, 127)),
            imms[i], 1'b0);
      step();
      n_run++;
      if (out_valid !== 1'b1 || out_inst !== exp[i]
          || out_addr !== 10'(i)) begin
        n_fail++;
        $display("FAIL directed_%0d: v=%b inst=%h addr=%0d want 1 %h %0d",
                 i, out_valid, out_inst, out_addr, exp[i], i);
      end
      n_run++;
      if (dec_imm(fmts[i], out_inst) !== imms[i]) begin
        n_fail++;
        $display("FAIL roundtrip_%0d: got %0d want %0d",
                 i, dec_imm(fmts[i], out_inst), imms[i]);
      end
    end
    idle();
    step();
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL directed_drain: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1, 'h13, 7, 8, 0, 0, 0, -1, 1'b0);
    step();
    n_run++;
    if (out_valid !== 1'b1 || out_inst !== 32'hFFF40393) begin
      n_fail++;
      $display("FAIL bp_first: v=%b inst=%h want 1 fff40393",
               out_valid, out_inst);
    end
    drive(4, 'h37, 9, 0, 0, 0, 0, 32'hABCDE000, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      n_run++;
      if (in_ready !== 1'b0 || out_inst !== 32'hFFF40393
          || out_addr !== 10'd0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: rdy=%b inst=%h addr=%0d want 0 fff40393 0",
                 c, in_ready, out_inst, out_addr);
      end
    end
    out_ready = 1'b1;
    #1;
    n_run++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: rdy=%b want 1", in_ready);
    end
    step();
    n_run++;
    if (out_valid !== 1'b1 || out_inst !== 32'hABCDE4B7
        || out_addr !== 10'd1) begin
      n_fail++;
      $display("FAIL bp_second: v=%b inst=%h addr=%0d want 1 abcde4b7 1",
               out_valid, out_inst, out_addr);
    end
    idle();
    step();
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: v=%b want 0", out_valid);
    end
  endtask

  task automatic test_errors();
    int ims[5]  = '{3, 2048, 0, 'h1001, 4095};
    int fms[5]  = '{3, 1, 7, 4, 3};
    int cds[5]  = '{1, 0, 3, 2, 0};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(fms[i], 'h63, 1, 2, 3, 0, 0, ims[i], i == 2);
      step();
      n_run++;
      if (out_valid !== 1'b0 || err_count !== 8'(i + 1)
          || err_code !== 2'(cds[i])) begin
        n_fail++;
        $display("FAIL err_%0d: v=%b cnt=%0d code=%0d want 0 %0d %0d",
                 i, out_valid, err_count, err_code, i + 1, cds[i]);
      end
      n_run++;
      if (done !== (i == 2)) begin
        n_fail++;
        $display("FAIL err_done_%0d: got %b want %b",
                 i, done, i == 2);
      end
    end
    drive(1, 'h13, 1, 2, 0, 0, 0, 5, 1'b0);
    step();
    n_run++;
    if (out_valid !== 1'b1 || out_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL err_noadv: v=%b addr=%0d want 1 0",
               out_valid, out_addr);
    end
    drive(6, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    for (int c = 0; c < 260; c++) step();
    n_run++;
    if (err_count !== 8'd255) begin
      n_fail++;
      $display("FAIL err_sat: got %0d want 255", err_count);
    end
    idle();
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 'h13, i, 0, 0, 0, 0, i, i == 4);
      step();
      n_run++;
      if (out_addr2 !== 2'(i % 4) || out_addr !== 10'(i)
          || done !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_%0d: a2=%0d a=%0d done=%b want %0d %0d 0",
                 i, out_addr2, out_addr, done, i % 4, i);
      end
    end
    idle();
    step();
    n_run++;
    if (done !== 1'b1 || done2 !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_done: done=%b/%b v=%b want 1/1 0",
               done, done2, out_valid);
    end
    step();
    n_run++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_done_end: got %b want 0", done);
    end
    drive(1, 'h13, 3, 0, 0, 0, 0, 7, 1'b0);
    step();
    n_run++;
    if (out_addr2 !== 2'd0 || out_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL wrap_reload: a2=%0d a=%0d want 0 0",
               out_addr2, out_addr);
    end
    idle();
    step();
  endtask

  task automatic test_reset_full();
    do_reset();
    out_ready = 1'b1;
    drive(7, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    step();
    out_ready = 1'b0;
    drive(1, 'h13, 1, 1, 0, 0, 0, 1, 1'b1);
    step();
    n_run++;
    if (out_valid !== 1'b1 || err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL rstfull_pre: v=%b cnt=%0d want 1 1",
               out_valid, err_count);
    end
    rst = 1'b1;
    idle();
    step();
    n_run++;
    if (out_valid !== 1'b0 || err_count !== 8'd0
        || out_addr !== 10'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstfull: v=%b cnt=%0d addr=%0d done=%b want 0 0 0 0",
               out_valid, err_count, out_addr, done);
    end
    rst = 1'b0;
    step();
    n_run++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstfull_post: done=%b rdy=%b want 0 1",
               done, in_ready);
    end
  endtask

  task automatic test_random();
    int          bnd[13] = '{-2048, 2047, 2048, -2049, -4096,
                             4094, 4095, -4098, -1048576,
                             1048574, 1048576, -1048578, 0};
    bit          m_full = 0;
    bit          m_last = 0;
    logic [31:0] m_inst = '0;
    int          m_addr = 0;
    int          m_errc = 0;
    int          m_code = 0;
    bit          e_done;
    bit          e_rdy;
    bit          acc;
    bit          cons;
    int          fmt, imm, r, e;
    logic [31:0] w;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      r   = int'($urandom_range(0, 15));
      fmt = (r < 13) ? r % 6 : 6 + (r % 2);
      case ($urandom_range(0, 3))
        0: imm = int'($urandom_range(0, 8191)) - 4096;
        1: imm = bnd[$urandom_range(0, 12)];
        2: imm = int'($urandom);
        default: imm = int'($urandom_range(0, 2097151)) - 1048576;
      endcase
      if (fmt == 4 && $urandom_range(0, 3) != 0) imm = imm & ~32'hFFF;
      if ((fmt == 3 || fmt == 5) && $urandom_range(0, 1) == 1)
        imm = imm & ~1;
      drive(fmt, int'($urandom), int'($urandom), int'($urandom),
            int'($urandom), int'($urandom), int'($urandom), imm,
            $urandom_range(0, 7) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      e_rdy = !m_full || out_ready;
      n_run++;
      if (in_ready !== e_rdy || in_ready2 !== e_rdy) begin
        n_fail++;
        $display("FAIL rand_ready_%0d: got %b/%b want %b",
                 c, in_ready, in_ready2, e_rdy);
      end
      acc  = in_valid && e_rdy;
      cons = m_full && out_ready;
      e    = ref_err(fmt, imm);
      w    = ref_enc(fmt, in_opcode, in_rd, in_rs1, in_rs2,
                     in_funct3, in_funct7, imm);
      e_done = (cons && m_last) || (acc && e >= 0 && in_last);
      if (cons) begin
        m_full = 0;
        m_addr = m_last ? 0 : (m_addr + 1) % 1024;
      end
      if (acc && e < 0) begin
        m_full = 1;
        m_inst = w;
        m_last = in_last;
      end
      if (acc && e >= 0) begin
        if (m_errc < 255) m_errc++;
        m_code = e;
      end
      step();
      n_run++;
      if (out_valid !== m_full || out_valid2 !== m_full
          || done !== e_done || err_count !== 8'(m_errc)
          || err_code !== 2'(m_code)) begin
        n_fail++;
        $display("FAIL rand_state_%0d: v=%b/%b done=%b cnt=%0d code=%0d want %b %b %0d %0d",
                 c, out_valid, out_valid2, done, err_count,
                 err_code, m_full, e_done, m_errc, m_code);
      end
      if (m_full) begin
        n_run++;
        if (out_inst !== m_inst || out_inst2 !== m_inst
            || out_addr !== 10'(m_addr)
            || out_addr2 !== 2'(m_addr % 4)) begin
          n_fail++;
          $display("FAIL rand_word_%0d: inst=%h addr=%0d/%0d want %h %0d",
                   c, out_inst, out_addr, out_addr2, m_inst, m_addr);
        end
      end
    end
    idle();
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_errors();
    test_wrap();
    test_reset_full();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
